// File: rtl/mmc_resp_receive_pkg.sv
// Shared constants, state encoding and CRC7 step for the MMC response path.
package mmc_resp_receive_pkg;

  localparam int RESP_LEN_SHORT = 48;
  localparam int RESP_LEN_LONG  = 136;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_START,
    S_RECV,
    S_FINISH
  } state_t;

  function automatic logic [6:0] crc7_step(
    input logic [6:0] crc,
    input logic       din
  );
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/mmc_crc7_serial.sv
// Bit-serial CRC7 (x^7+x^3+1), MSB-first, zero initial value.
module mmc_crc7_serial
  import mmc_resp_receive_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_step(crc, din);
    end
  end

endmodule

// File: rtl/mmc_resp_receive.sv
// MMC CMD-line response receiver: waits for start bit, shifts in an
// R1/R3 (48-bit) or R2 (136-bit) frame and checks CRC7 and framing.
module mmc_resp_receive
  import mmc_resp_receive_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        long_resp,
  input  logic        crc_chk,
  input  logic        bit_en,
  input  logic        cmd_in,
  output logic        busy,
  output logic        done,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic        crc_err,
  output logic        frame_err,
  output logic        timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic          long_q;
  logic          chk_q;
  logic [7:0]    cnt;
  logic [TW-1:0] tcnt;
  logic [39:0]   sr;
  logic [39:0]   sr_nx;
  logic [5:0]    hdr;
  logic [6:0]    crc;
  logic [7:0]    len;
  logic [7:0]    pay_end;
  logic [7:0]    feed_lo;
  logic          in_feed;
  logic          crc_clr;
  logic          crc_en;

  assign sr_nx   = {sr[38:0], cmd_in};
  assign len     = long_q ? 8'(RESP_LEN_LONG) : 8'(RESP_LEN_SHORT);
  assign pay_end = len - 8'd9;
  // R2 excludes its 8-bit header from the CRC
  assign feed_lo = long_q ? 8'd8 : 8'd1;
  assign in_feed = (cnt >= feed_lo) && (cnt <= pay_end);

  assign crc_clr = (state == S_IDLE) && start;
  assign crc_en  = bit_en &&
                   (((state == S_WAIT_START) && !cmd_in) ||
                    ((state == S_RECV) && in_feed));

  mmc_crc7_serial u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (crc_clr),
    .en      (crc_en),
    .din     (cmd_in),
    .crc     (crc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      long_q     <= 1'b0;
      chk_q      <= 1'b0;
      cnt        <= '0;
      tcnt       <= '0;
      sr         <= '0;
      hdr        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      resp_index <= '0;
      resp_arg   <= '0;
      crc_err    <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            long_q     <= long_resp;
            chk_q      <= crc_chk;
            cnt        <= '0;
            tcnt       <= '0;
            busy       <= 1'b1;
            resp_index <= '0;
            resp_arg   <= '0;
            crc_err    <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
            state      <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (bit_en) begin
            if (!cmd_in) begin
              cnt   <= 8'd1;
              state <= S_RECV;
            end else begin
              if (tcnt != TW'(TIMEOUT)) begin
                tcnt <= tcnt + TW'(1);
              end
              if (tcnt == TW'(TIMEOUT - 1)) begin
                timeout <= 1'b1;
                done    <= 1'b1;
                busy    <= 1'b0;
                state   <= S_FINISH;
              end
            end
          end
        end
        S_RECV: begin
          if (bit_en) begin
            sr  <= sr_nx;
            cnt <= cnt + 8'd1;
            if (cnt == 8'd1 && cmd_in) begin
              frame_err <= 1'b1;
            end
            // header index is complete after 8 bits in both formats
            if (cnt == 8'd7) begin
              hdr <= sr_nx[5:0];
            end
            if (cnt == pay_end) begin
              resp_index <= hdr;
              resp_arg   <= sr_nx[31:0];
            end
            if (cnt == len - 8'd1) begin
              if (!cmd_in) begin
                frame_err <= 1'b1;
              end
              // sr[6:0] now holds the received CRC field, MSB first
              if (chk_q && (sr[6:0] != crc)) begin
                crc_err <= 1'b1;
              end
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmc_resp_receive.sv
// Self-checking bench for mmc_resp_receive with a frame-level reference model.
module tb_mmc_resp_receive;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        long_resp = 1'b0;
  logic        crc_chk = 1'b0;
  logic        bit_en = 1'b0;
  logic        cmd_in = 1'b1;
  logic        busy;
  logic        done;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;
  logic        crc_err;
  logic        frame_err;
  logic        timeout;

  mmc_resp_receive #(.TIMEOUT(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .long_resp  (long_resp),
    .crc_chk    (crc_chk),
    .bit_en     (bit_en),
    .cmd_in     (cmd_in),
    .busy       (busy),
    .done       (done),
    .resp_index (resp_index),
    .resp_arg   (resp_arg),
    .crc_err    (crc_err),
    .frame_err  (frame_err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  bit armed = 0;
  bit hold = 0;
  bit done_seen = 0;

  logic [5:0]  exp_idx;
  logic [31:0] exp_arg;
  logic        exp_crc;
  logic        exp_frm;
  logic        exp_to;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // CRC7 as remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_div(input logic [135:0] fr,
                                          input int hi, input int lo);
    logic [142:0] r;
    int n;
    n = hi - lo + 1;
    r = '0;
    for (int i = 0; i < n; i++) r[i+7] = fr[lo+i];
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [135:0] make_short(input logic tx,
      input logic [5:0] idx, input logic [31:0] arg);
    logic [135:0] f;
    f = '0;
    f[46] = tx;
    f[45:40] = idx;
    f[39:8] = arg;
    f[7:1] = crc7_div(f, 47, 8);
    f[0] = 1'b1;
    return f;
  endfunction

  function automatic logic [135:0] make_long(input logic [119:0] body);
    logic [135:0] f;
    f = '0;
    f[133:128] = 6'h3F;
    f[127:8] = body;
    f[7:1] = crc7_div(f, 127, 8);
    f[0] = 1'b1;
    return f;
  endfunction

  task automatic set_expect(input logic [135:0] fr, input bit lng,
                            input bit chk);
    int n;
    n = lng ? 136 : 48;
    exp_idx = lng ? fr[133:128] : fr[45:40];
    exp_arg = fr[39:8];
    exp_crc = chk && (fr[7:1] != crc7_div(fr, lng ? 127 : 47, 8));
    exp_frm = fr[n-2] || !fr[0];
    exp_to  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (!armed) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected 0",
                   cyc);
        end else begin
          check("done_idx", resp_index, exp_idx);
          check("done_arg", resp_arg, exp_arg);
          check("done_crc_err", crc_err, exp_crc);
          check("done_frame_err", frame_err, exp_frm);
          check("done_timeout", timeout, exp_to);
          check("done_busy", busy, 1'b0);
          armed = 0;
          done_seen = 1;
          done_cyc = cyc;
          hold = 1;
        end
      end else if (hold) begin
        check("hold_crc_err", crc_err, exp_crc);
        check("hold_frame_err", frame_err, exp_frm);
        check("hold_timeout", timeout, exp_to);
      end
    end
  end

  task automatic pulse_start(input bit lng, input bit chk);
    hold = 0;
    done_seen = 0;
    start = 1'b1;
    long_resp = lng;
    crc_chk = chk;
    @(negedge clk);
    start = 1'b0;
    long_resp = $urandom_range(0, 1);
    crc_chk = $urandom_range(0, 1);
    armed = 1;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic idle_strobes(input int k);
    for (int i = 0; i < k; i++) begin
      bit_en = 1'b1;
      cmd_in = 1'b1;
      @(negedge clk);
    end
  endtask

  // gapped mode inserts a dead cycle (random cmd_in) after every 3rd bit
  task automatic send_bits(input logic [135:0] fr, input int hi,
                           input int lo, input bit gaps);
    for (int k = hi; k >= lo; k--) begin
      bit_en = 1'b1;
      cmd_in = fr[k];
      @(negedge clk);
      if (k == hi) start_cyc = cyc;
      if (gaps && (k % 3 == 0)) begin
        bit_en = 1'b0;
        cmd_in = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    bit_en = 1'b0;
    cmd_in = 1'b1;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (done_seen) break;
      @(negedge clk);
    end
    check(name, done_seen, 1'b1);
    @(negedge clk);
  endtask

  // edges from the start-bit edge to the first edge sampling done, inclusive
  function automatic int latency();
    return done_cyc - start_cyc + 2;
  endfunction

  logic [135:0] f;
  logic [135:0] g;
  int t64;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_idx", resp_index, 6'd0);
    check("rst_arg", resp_arg, 32'd0);
    check("rst_flags", {crc_err, frame_err, timeout}, 3'b000);
    reset_n = 1'b1;
    @(negedge clk);

    f = make_short(1'b1, 6'd0, 32'd0);
    check("model_crc_cmd0", crc7_div(f, 47, 8), 7'h4A);
    f = make_short(1'b1, 6'd8, 32'h0000_01AA);
    check("model_crc_cmd8", crc7_div(f, 47, 8), 7'h43);

    // R1, valid CRC, 5 idle strobes
    f = make_short(1'b0, 6'd3, 32'h0001_0500);
    set_expect(f, 1'b0, 1'b1);
    check("model_r1_flags", {exp_crc, exp_frm}, 2'b00);
    pulse_start(1'b0, 1'b1);
    idle_strobes(5);
    send_bits(f, 47, 0, 1'b0);
    wait_done("r1_done");
    check("r1_idx_lit", resp_index, 6'd3);
    check("r1_arg_lit", resp_arg, 32'h0001_0500);
    check("r1_flags_lit", {crc_err, frame_err, timeout}, 3'b000);
    check("r1_latency", latency(), 49);

    // CRC bit 3 flipped
    g = f;
    g[4] = ~g[4];
    set_expect(g, 1'b0, 1'b1);
    pulse_start(1'b0, 1'b1);
    idle_strobes(2);
    send_bits(g, 47, 0, 1'b0);
    wait_done("crcbad_done");
    check("crcbad_lit", crc_err, 1'b1);

    // R3: CRC field all ones, check disabled, gapped bit_en
    g = make_short(1'b0, 6'h3F, 32'h80FF_8000);
    g[7:1] = 7'h7F;
    set_expect(g, 1'b0, 1'b0);
    pulse_start(1'b0, 1'b0);
    idle_strobes(3);
    send_bits(g, 47, 0, 1'b1);
    wait_done("r3_done");
    check("r3_crc_lit", crc_err, 1'b0);
    check("r3_idx_lit", resp_index, 6'h3F);
    check("r3_arg_lit", resp_arg, 32'h80FF_8000);

    // R2 long frame
    f = make_long({88'h0123456789ABCDEF012345, 32'hDEAD_BEEF});
    set_expect(f, 1'b1, 1'b1);
    pulse_start(1'b1, 1'b1);
    idle_strobes(2);
    send_bits(f, 135, 0, 1'b0);
    wait_done("r2_done");
    check("r2_arg_lit", resp_arg, 32'hDEAD_BEEF);
    check("r2_idx_lit", resp_index, 6'h3F);
    check("r2_crc_lit", crc_err, 1'b0);
    check("r2_latency", latency(), 137);

    // timeout: 64 strobes of idle line
    exp_idx = '0;
    exp_arg = '0;
    exp_crc = 1'b0;
    exp_frm = 1'b0;
    exp_to  = 1'b1;
    pulse_start(1'b0, 1'b1);
    idle_strobes(64);
    t64 = cyc;
    bit_en = 1'b0;
    wait_done("to_done");
    check("to_done_cycle", done_cyc, t64);
    check("to_flag_lit", timeout, 1'b1);
    check("to_arg_lit", resp_arg, 32'd0);

    // stop bit forced low
    g = make_short(1'b0, 6'd5, 32'h1234_5678);
    g[0] = 1'b0;
    set_expect(g, 1'b0, 1'b1);
    pulse_start(1'b0, 1'b1);
    idle_strobes(1);
    send_bits(g, 47, 0, 1'b0);
    wait_done("stop_done");
    check("stop_frm_lit", frame_err, 1'b1);

    // transmission bit forced high (CRC still consistent)
    g = make_short(1'b1, 6'd5, 32'h1234_5678);
    set_expect(g, 1'b0, 1'b1);
    pulse_start(1'b0, 1'b1);
    idle_strobes(1);
    send_bits(g, 47, 0, 1'b1);
    wait_done("tx_done");
    check("tx_frm_lit", frame_err, 1'b1);
    check("tx_crc_lit", crc_err, 1'b0);

    // reset at bit 20 of a frame
    f = make_short(1'b0, 6'd17, 32'hCAFE_F00D);
    set_expect(f, 1'b0, 1'b1);
    pulse_start(1'b0, 1'b1);
    send_bits(f, 47, 28, 1'b0);
    armed = 0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_idx", resp_index, 6'd0);
    check("mid_rst_arg", resp_arg, 32'd0);
    check("mid_rst_flags", {crc_err, frame_err, timeout}, 3'b000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bit_en = 1'($urandom_range(0, 1));
      cmd_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bit_en = 1'b0;
    cmd_in = 1'b1;
    check("post_rst_busy", busy, 1'b0);
    pulse_start(1'b0, 1'b1);
    idle_strobes(3);
    send_bits(f, 47, 0, 1'b0);
    wait_done("post_rst_done");
    check("post_rst_idx_lit", resp_index, 6'd17);
    check("post_rst_arg_lit", resp_arg, 32'hCAFE_F00D);
    check("post_rst_latency", latency(), 49);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
